// File: rtl/rn_prf_busytable.sv
// Rename-stage physical register busy table: per-cycle set/clear, read-port
// writeback bypass, and snapshot slots for branch-mispredict recovery.

module rn_prf_busytable_rdport #(
  parameter int NPRF   = 64,
  parameter int AW     = 6,
  parameter int BYPASS = 1
) (
  input  logic [NPRF-1:0] busy,
  input  logic [NPRF-1:0] clr,
  input  logic [AW-1:0]   prs,
  output logic            rd_busy
);
  localparam logic BYP = (BYPASS != 0);

  // Same-cycle allocations are deliberately invisible; rename resolves them.
  assign rd_busy = busy[prs] & ~(BYP & clr[prs]);
endmodule

module rn_prf_busytable #(
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_PRF_AW        = 6,
  parameter int CONFIG_P_WB_WIDTH    = 1,
  parameter int CONFIG_P_CKPT        = 2,
  parameter int CONFIG_BYPASS        = 1,
  localparam int IW   = 1 << CONFIG_P_ISSUE_WIDTH,
  localparam int AW   = CONFIG_PRF_AW,
  localparam int NPRF = 1 << CONFIG_PRF_AW,
  localparam int NWB  = 1 << CONFIG_P_WB_WIDTH,
  localparam int NCK  = 1 << CONFIG_P_CKPT,
  localparam int NRD  = 2 * IW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IW-1:0][AW-1:0]             alloc_prd,
  input  logic [IW-1:0]                     alloc_we,
  input  logic [NWB-1:0][AW-1:0]            wb_prd,
  input  logic [NWB-1:0]                    wb_we,
  input  logic [NRD-1:0][AW-1:0]            rd_prs,
  output logic [NRD-1:0]                    rd_busy,
  input  logic                              ckpt_we,
  input  logic [CONFIG_P_CKPT-1:0]          ckpt_id,
  input  logic                              rec_valid,
  input  logic [CONFIG_P_CKPT-1:0]          rec_id,
  output logic [NPRF-1:0]                   busytable
);

  logic [NPRF-1:0]           set_vec, clr_vec, nrm_next;
  logic [NPRF-1:0]           busy_d, busy_q;
  logic [NCK-1:0][NPRF-1:0]  ckpt_d, ckpt_q;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int k = 0; k < IW; k++)
      if (alloc_we[k]) set_vec[alloc_prd[k]] = 1'b1;
    for (int j = 0; j < NWB; j++)
      if (wb_we[j]) clr_vec[wb_prd[j]] = 1'b1;
  end

  // Snapshots keep absorbing writebacks so a restore never resurrects a
  // register that has already completed.
  always_comb begin
    nrm_next    = (busy_q & ~clr_vec) | set_vec;
    nrm_next[0] = 1'b0;
    busy_d      = rec_valid ? (ckpt_q[rec_id] & ~clr_vec) : nrm_next;
    busy_d[0]   = 1'b0;
    for (int i = 0; i < NCK; i++) begin
      if (!rec_valid && ckpt_we && ckpt_id == CONFIG_P_CKPT'(i))
        ckpt_d[i] = nrm_next;
      else
        ckpt_d[i] = ckpt_q[i] & ~clr_vec;
      ckpt_d[i][0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      ckpt_q <= '0;
    end else begin
      busy_q <= busy_d;
      ckpt_q <= ckpt_d;
    end
  end

  for (genvar n = 0; n < NRD; n++) begin : g_rd
    rn_prf_busytable_rdport #(
      .NPRF   (NPRF),
      .AW     (AW),
      .BYPASS (CONFIG_BYPASS)
    ) u_rd (
      .busy    (busy_q),
      .clr     (clr_vec),
      .prs     (rd_prs[n]),
      .rd_busy (rd_busy[n])
    );
  end

  assign busytable = busy_q;

endmodule
